// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: state enum,
// opcode constants, mux/ALU select encodings, the bundled control word
// and the legal R-type func check used when MULTICYCLE_ILLEGAL_TRAP_EN is defined.
package multicycle_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    , ST_TRAP = 4'd12
`endif
  } state_t;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp encodings
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSource encodings
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Legal R-type func codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  // One datapath control word; field order is the order of the top-level ports.
  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic is_legal_func(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_outputs.sv
// Purely combinational decode of the current state (plus memAck in FETCH)
// into the datapath control word. Anything not driven for a state stays 0.
module control_outputs
  import multicycle_pkg::*;
(
  input  state_t state,
  input  logic   mem_ack,
  output ctrl_t  ctrl
);

  // Per-state control decode.
  always_comb begin
    // NOTE: default the whole word first so every path assigns every bit (no latches).
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR capture and PC+4 happen only on the cycle the word arrives.
        ctrl.ir_write  = mem_ack;
        ctrl.pc_write  = mem_ack;
      end
      ST_DECODE: begin
        // Branch target PC + (imm << 2) into ALUOut, speculatively.
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      ST_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      ST_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        // PC load is gated by zero in the datapath via PCWriteCond.
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b0;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      // TRAP (when built) and any unused encoding keep every control at 0.
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: state register and next-state logic.
// Control outputs come from control_outputs and are forced to 0 while
// reset is high. Optional illegal-instruction trap: MULTICYCLE_ILLEGAL_TRAP_EN.
module multicycle_control
  import multicycle_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       memAck,
  output logic       memReq,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  , output logic     illegalOp
`endif
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_dec;
  ctrl_t  ctrl_out;

  // The zero flag qualifies the PC load inside the datapath (PCWriteCond & zero);
  // the sequence itself does not depend on it.
  logic unused_zero;
  assign unused_zero = zero;

`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
  // Without the trap, func is never inspected.
  logic unused_func;
  assign unused_func = ^func;
`endif

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; memory states hold until memAck.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (memAck) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opCode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          OP_RTYPE:     state_d = is_legal_func(func) ? ST_EXEC : ST_TRAP;
`else
          OP_RTYPE:     state_d = ST_EXEC;
`endif
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMP;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:      state_d = ST_TRAP;
`else
          // Unknown opcode executes as a two-cycle NOP.
          default:      state_d = ST_FETCH;
`endif
        endcase
      end
      ST_MEMADR: state_d = (opCode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (memAck) state_d = ST_MEMWB;
      ST_MEMWB:  state_d = ST_FETCH;
      ST_MEMWR:  if (memAck) state_d = ST_FETCH;
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ALUWB:  state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_ADDIWB: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      ST_TRAP:   state_d = ST_TRAP;
`endif
      default:   state_d = ST_FETCH;
    endcase
  end

  control_outputs u_control_outputs (
    .state   (state_q),
    .mem_ack (memAck),
    .ctrl    (ctrl_dec)
  );

  // Output stage: reset forces every control (and the debug state) to 0 in the
  // same cycle, so an in-flight memory request is dropped immediately.
  always_comb begin
    ctrl_out = ctrl_dec;
    state    = state_q;
    if (reset) begin
      ctrl_out = '0;
      state    = 4'd0;
    end
  end

  assign memReq      = ctrl_out.mem_req;
  assign MemRead     = ctrl_out.mem_read;
  assign MemWrite    = ctrl_out.mem_write;
  assign IorD        = ctrl_out.iord;
  assign IRWrite     = ctrl_out.ir_write;
  assign PCWrite     = ctrl_out.pc_write;
  assign PCWriteCond = ctrl_out.pc_write_cond;
  assign RegWrite    = ctrl_out.reg_write;
  assign RegDst      = ctrl_out.reg_dst;
  assign MemtoReg    = ctrl_out.mem_to_reg;
  assign ALUSrcA     = ctrl_out.alu_src_a;
  assign ALUSrcB     = ctrl_out.alu_src_b;
  assign ALUOp       = ctrl_out.alu_op;
  assign PCSource    = ctrl_out.pc_source;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  // TRAP is left only through reset, so the flag is sticky by construction.
  assign illegalOp = (state_q == ST_TRAP) && !reset;
`endif

endmodule
